// File: rtl/mips_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mips_dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter slice:
//     - ByteWidth encodings used on cpu_bw / dma_bw / mem_bw
//     - owner state encoding for the arbiter FSM
//     - default starvation and burst limits
// ---------------------------------------------------------------------------
package mips_dmem_arbiter_pkg;

    // ByteWidth encodings driven to MIPSDataMem
    localparam logic [1:0] BW_BYTE = 2'b00;
    localparam logic [1:0] BW_HALF = 2'b01;
    localparam logic [1:0] BW_WORD = 2'b11;

    // Owner FSM: S_DMA means DMA holds a locked burst
    typedef enum logic {
        S_IDLE = 1'b0,
        S_DMA  = 1'b1
    } owner_e;

    // Default arbitration limits
    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_BURST_MAX  = 8;
    localparam int DEF_CNT_W      = 4;

endpackage : mips_dmem_arbiter_pkg

// File: rtl/mips_dmem_req_mux.sv
// ---------------------------------------------------------------------------
// mips_dmem_req_mux
//   Pure combinational 2:1 steering between the CPU and DMA request sides
//   and the single data-memory port. The selection comes from the one-hot
//   grant pair {cpu_gnt, dma_gnt}; with no grant the memory sees an idle,
//   all-zero request (in particular mem_we=0, mem_addr=0).
//   Response side: mem_rdata is broadcast to both requesters, mem_err is
//   routed only to the granted requester.
// Ports
//   cpu_gnt, dma_gnt                 in  grant pair (at most one set)
//   cpu_* / dma_*                    in  request fields of each side
//   mem_addr/we/wdata/bw/sext        out request to data memory
//   mem_rdata, mem_err               in  response from data memory
//   cpu_rdata/dma_rdata              out broadcast load data
//   cpu_err/dma_err                  out error qualified by own grant
// ---------------------------------------------------------------------------
module mips_dmem_req_mux
    import mips_dmem_arbiter_pkg::*;
(
    input  logic        cpu_gnt,
    input  logic        dma_gnt,

    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_bw,
    input  logic        cpu_sext,

    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_bw,
    input  logic        dma_sext,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_bw,
    output logic        mem_sext,

    input  logic [31:0] mem_rdata,
    input  logic        mem_err,

    output logic [31:0] cpu_rdata,
    output logic [31:0] dma_rdata,
    output logic        cpu_err,
    output logic        dma_err
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through this block leaves a signal unassigned (no latch).
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_bw    = BW_BYTE;
        mem_sext  = 1'b0;

        case ({cpu_gnt, dma_gnt})
            2'b10: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                mem_bw    = cpu_bw;
                mem_sext  = cpu_sext;
            end
            2'b01: begin
                mem_addr  = dma_addr;
                mem_we    = dma_we;
                mem_wdata = dma_wdata;
                mem_bw    = dma_bw;
                mem_sext  = dma_sext;
            end
            default: ; // no grant: idle request
        endcase
    end

    // Consumers qualify rdata with their own grant
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign cpu_err   = mem_err & cpu_gnt;
    assign dma_err   = mem_err & dma_gnt;

endmodule : mips_dmem_req_mux

// File: rtl/mips_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_dmem_arbiter
//   Shares MIPSDataMem between the CPU load/store path and a DMA/loader
//   port. Zero latency: grant, memory drive and read data all happen in the
//   same cycle; a store commits at the clock edge ending the granted cycle.
//   CPU has default priority. A starvation counter forces a DMA win after
//   STARVE_MAX lost DMA cycles, and dma_lock lets DMA hold the memory for
//   up to BURST_MAX consecutive grants before it is forced to release.
//   While reset is low every output is driven to zero.
// Ports
//   clk, reset (async, active-low)
//   cpu_req/we/addr/wdata/bw/sext    in  CPU request
//   cpu_gnt, cpu_stall, cpu_rdata, cpu_err   out CPU response
//   dma_req/we/addr/wdata/bw/sext    in  DMA request
//   dma_lock                         in  DMA burst ownership request
//   dma_gnt, dma_rdata, dma_err      out DMA response
//   mem_addr/we/wdata/bw/sext        out data-memory request
//   mem_rdata, mem_err               in  data-memory response
// ---------------------------------------------------------------------------
module mips_dmem_arbiter
    import mips_dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_bw,
    input  logic        cpu_sext,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_bw,
    input  logic        dma_sext,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_err,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_bw,
    output logic        mem_sext,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    owner_e             state,      state_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_nxt;
    logic [CNT_W-1:0]   burst_cnt,  burst_nxt;

    logic               lock_ok;    // S_DMA and the burst may continue
    logic               starve_hit; // DMA has waited long enough to win
    logic [31:0]        mux_cpu_rdata, mux_dma_rdata;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        lock_ok    = (state == S_DMA) && dma_req && dma_lock && (burst_cnt < BURST_LIM);
        // Starvation only counts in S_IDLE; once a burst fails it is
        // arbitrated as if starve_cnt were zero.
        starve_hit = (state == S_IDLE) && (starve_cnt >= STARVE_LIM);

        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            // reset asserted: no grants, outputs forced low
        end else if (lock_ok) begin
            dma_gnt = 1'b1;
        end else if (dma_req && starve_hit) begin
            dma_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_gnt;

    // ------------------------------------------------------------------
    // Next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;

        unique case (state)
            S_IDLE: begin
                if (dma_gnt && dma_lock) begin
                    state_nxt = S_DMA;
                    burst_nxt = CNT_ONE;
                end
            end
            S_DMA: begin
                if (lock_ok) begin
                    burst_nxt = burst_cnt + CNT_ONE;
                end else begin
                    state_nxt = S_IDLE;
                    burst_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                burst_nxt = '0;
            end
        endcase

        // Releasing a burst clears starvation so a waiting CPU wins next.
        if ((state == S_DMA) && !lock_ok) begin
            starve_nxt = '0;
        end else if (dma_req && !dma_gnt) begin
            starve_nxt = (starve_cnt == '1) ? starve_cnt : starve_cnt + CNT_ONE;
        end else begin
            starve_nxt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request / response steering
    // ------------------------------------------------------------------
    mips_dmem_req_mux u_req_mux (
        .cpu_gnt   (cpu_gnt),
        .dma_gnt   (dma_gnt),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_bw    (cpu_bw),
        .cpu_sext  (cpu_sext),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_bw    (dma_bw),
        .dma_sext  (dma_sext),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_bw    (mem_bw),
        .mem_sext  (mem_sext),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .cpu_rdata (mux_cpu_rdata),
        .dma_rdata (mux_dma_rdata),
        .cpu_err   (cpu_err),
        .dma_err   (dma_err)
    );

    // Grants are already low in reset, so only the broadcast rdata needs
    // explicit gating to keep every output at zero.
    assign cpu_rdata = reset ? mux_cpu_rdata : '0;
    assign dma_rdata = reset ? mux_dma_rdata : '0;

endmodule : mips_dmem_arbiter
